ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL declare parameter CLK_INHIBIT_CYCLES, default 5000: number of Clk cycles the host holds PS/2 clock low before the start bit (100 us at 50 MHz).
REQ-002 SHALL declare parameter RTS_HOLD_CYCLES, default 20: number of Clk cycles clock stays low after data is pulled low.
REQ-003 SHALL declare parameter TIMEOUT_CYCLES, default 750000: maximum Clk cycles allowed between device clock falling edges (15 ms).
REQ-004 SHALL have port Clk, input, 1 bit: system clock (50 MHz); the block uses only this clock.
REQ-005 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port tx_data, input, 8 bits: command byte to send to the keyboard.
REQ-007 SHALL have port tx_start, input, 1 bit: one-cycle request; sampled only in IDLE.
REQ-008 SHALL have port psClk_in, input, 1 bit: raw PS/2 clock line level.
REQ-009 SHALL have port psData_in, input, 1 bit: raw PS/2 data line level.
REQ-010 SHALL have port psClk_oe, output, 1 bit: 1 drives PS/2 clock low (open-drain); 0 releases it.
REQ-011 SHALL have port psData_oe, output, 1 bit: 1 drives PS/2 data low (open-drain); 0 releases it.
REQ-012 SHALL have port busy, output, 1 bit: high from tx_start acceptance until done.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse marking the end of a transfer.
REQ-014 SHALL have port ack_err, output, 1 bit: device did not ack; valid with done and held until the next accepted start.
REQ-015 SHALL have port timeout, output, 1 bit: clock edge timeout; valid with done and held until the next accepted start.

Function
REQ-016 SHALL synchronize psClk_in and psData_in through two flip-flops before any use; a falling edge is synchronized clock going 1 to 0.
REQ-017 SHALL implement the states IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE and FINISH.
REQ-018 SHALL, in IDLE on tx_start, latch tx_data and odd parity (~^tx_data), clear ack_err and timeout, set busy, assert psClk_oe, and go to INHIBIT.
REQ-019 SHALL, in INHIBIT after CLK_INHIBIT_CYCLES cycles, assert psData_oe (start bit 0) and go to RTS.
REQ-020 SHALL, in RTS after RTS_HOLD_CYCLES cycles, deassert psClk_oe and go to SEND with the bit index at 0.
REQ-021 SHALL, in SEND on each falling edge, present the next bit: edges 1-8 carry data bits 0-7 (LSB first), edge 9 carries parity, and edge 10 carries stop (psData_oe=0); psData_oe SHALL equal the inverse of the current bit.
REQ-022 SHALL, after edge 10, go to ACK; on edge 11 it SHALL sample synchronized data, with 0 meaning ack and 1 setting ack_err, then go to WAIT_IDLE.
REQ-023 SHALL, in WAIT_IDLE once synchronized clock and data are both 1, go to FINISH, pulse done for one cycle, clear busy and return to IDLE.
REQ-024 SHALL, in SEND, ACK and WAIT_IDLE, reset a timeout counter on every falling edge; on reaching TIMEOUT_CYCLES it SHALL release both lines, set timeout, pulse done and return to IDLE.
REQ-025 SHALL ignore tx_start whenever busy is high; the latched byte SHALL NOT change mid-transfer.
REQ-026 SHALL size the inhibit, RTS and timeout counters to ceil(log2(parameter+1)); the counters SHALL saturate and never wrap.
REQ-027 SHALL never assert psClk_oe outside INHIBIT and RTS.

Reset
REQ-028 SHALL, on Reset assertion, immediately and asynchronously force IDLE, with psClk_oe, psData_oe, busy, done, ack_err and timeout all 0, and clear the counters, the bit index and the synchronizers (to 1).
REQ-029 SHALL, when reset is asserted mid-transfer, release both lines within the same cycle and produce no done pulse.

Configuration
REQ-030 SHALL, when macro PS2_TX_GLITCH_FILTER_EN is defined, add an 8-sample debounce after the synchronizer: the filtered clock changes only after 8 consecutive identical samples, and edges are detected on the filtered clock.
REQ-031 SHALL, without PS2_TX_GLITCH_FILTER_EN, detect edges directly on the two-flip-flop synchronized clock, adding no extra latency.

Verification
REQ-032 SHALL cover: tx_data=0xED with a device model that acks -> clock low for at least 5000 cycles, bits sent 1,0,1,1,0,1,1,1, parity 1, stop, done pulse, ack_err=0, timeout=0.
REQ-033 SHALL cover: tx_data=0x07 -> parity bit 0 and done with ack_err=0.
REQ-034 SHALL cover: device model holds data at 1 on edge 11 -> done with ack_err=1.
REQ-035 SHALL cover: device stops clocking after edge 4 -> done 750000 cycles after the last edge, timeout=1, both oe outputs 0.
REQ-036 SHALL cover: Reset asserted during SEND at edge 5 -> oe outputs and busy go to 0 in the same cycle, no done pulse, and the next tx_start of 0xFF completes normally.
REQ-037 SHALL cover: tx_start pulsed while busy -> ignored, and the original byte is transmitted unaltered.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send, then shifts a byte, odd parity and stop out on device clock edges.
// Define PS2_TX_GLITCH_FILTER_EN to add an 8-sample debounce on the synchronized PS/2 clock.
module ps2_host_tx #(
  parameter int CLK_INHIBIT_CYCLES = 5000,
  parameter int RTS_HOLD_CYCLES    = 20,
  parameter int TIMEOUT_CYCLES     = 750000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       psClk_in,
  input  logic       psData_in,
  output logic       psClk_oe,
  output logic       psData_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int INH_W = $clog2(CLK_INHIBIT_CYCLES + 1);
  localparam int RTS_W = $clog2(RTS_HOLD_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(CLK_INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_MAX  = INH_W'(CLK_INHIBIT_CYCLES);
  localparam logic [RTS_W-1:0] RTS_LAST = RTS_W'(RTS_HOLD_CYCLES - 1);
  localparam logic [RTS_W-1:0] RTS_MAX  = RTS_W'(RTS_HOLD_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, FINISH
  } state_t;

  logic clkMeta_q, clkSync_q, dataMeta_q, dataSync_q;
  logic clkLine, clkPrev_q, fallEdge;

  // Lines idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clkMeta_q  <= 1'b1;
      clkSync_q  <= 1'b1;
      dataMeta_q <= 1'b1;
      dataSync_q <= 1'b1;
    end else begin
      clkMeta_q  <= psClk_in;
      clkSync_q  <= clkMeta_q;
      dataMeta_q <= psData_in;
      dataSync_q <= dataMeta_q;
    end
  end

`ifdef PS2_TX_GLITCH_FILTER_EN
  logic       clkFilt_q;
  logic [2:0] filtCnt_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clkFilt_q <= 1'b1;
      filtCnt_q <= 3'd0;
    end else if (clkSync_q == clkFilt_q) begin
      filtCnt_q <= 3'd0;
    end else if (filtCnt_q == 3'd7) begin
      clkFilt_q <= clkSync_q;
      filtCnt_q <= 3'd0;
    end else begin
      filtCnt_q <= filtCnt_q + 3'd1;
    end
  end

  assign clkLine = clkFilt_q;
`else
  assign clkLine = clkSync_q;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) clkPrev_q <= 1'b1;
    else       clkPrev_q <= clkLine;
  end

  assign fallEdge = clkPrev_q & ~clkLine;

  state_t           state_q, state_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       bitIdx_q, bitIdx_d;
  logic [INH_W-1:0] inhCnt_q, inhCnt_d;
  logic [RTS_W-1:0] rtsCnt_q, rtsCnt_d;
  logic [TO_W-1:0]  toCnt_q, toCnt_d;
  logic             clkOe_q, clkOe_d;
  logic             dataOe_q, dataOe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ackErr_q, ackErr_d;
  logic             timeout_q, timeout_d;
  logic             onWire;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitIdx_q  <= '0;
      inhCnt_q  <= '0;
      rtsCnt_q  <= '0;
      toCnt_q   <= '0;
      clkOe_q   <= 1'b0;
      dataOe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ackErr_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitIdx_q  <= bitIdx_d;
      inhCnt_q  <= inhCnt_d;
      rtsCnt_q  <= rtsCnt_d;
      toCnt_q   <= toCnt_d;
      clkOe_q   <= clkOe_d;
      dataOe_q  <= dataOe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ackErr_q  <= ackErr_d;
      timeout_q <= timeout_d;
    end
  end

  assign onWire = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);

  // shift_q holds {parity, data}; bitIdx_q counts device clock falls seen in SEND.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitIdx_d  = bitIdx_q;
    inhCnt_d  = inhCnt_q;
    rtsCnt_d  = rtsCnt_q;
    toCnt_d   = toCnt_q;
    clkOe_d   = clkOe_q;
    dataOe_d  = dataOe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ackErr_d  = ackErr_q;
    timeout_d = timeout_q;

    if (onWire) begin
      if (fallEdge)              toCnt_d = '0;
      else if (toCnt_q != TO_MAX) toCnt_d = toCnt_q + 1'b1;
    end

    if (onWire && !fallEdge && (toCnt_q == TO_LAST)) begin
      state_d   = IDLE;
      clkOe_d   = 1'b0;
      dataOe_d  = 1'b0;
      timeout_d = 1'b1;
      done_d    = 1'b1;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tx_start) begin
            shift_d   = {~^tx_data, tx_data};
            ackErr_d  = 1'b0;
            timeout_d = 1'b0;
            busy_d    = 1'b1;
            clkOe_d   = 1'b1;
            inhCnt_d  = '0;
            state_d   = INHIBIT;
          end
        end
        INHIBIT: begin
          if (inhCnt_q == INH_LAST) begin
            dataOe_d = 1'b1;
            rtsCnt_d = '0;
            state_d  = RTS;
          end else if (inhCnt_q != INH_MAX) begin
            inhCnt_d = inhCnt_q + 1'b1;
          end
        end
        RTS: begin
          if (rtsCnt_q == RTS_LAST) begin
            clkOe_d  = 1'b0;
            bitIdx_d = 4'd0;
            toCnt_d  = '0;
            state_d  = SEND;
          end else if (rtsCnt_q != RTS_MAX) begin
            rtsCnt_d = rtsCnt_q + 1'b1;
          end
        end
        SEND: begin
          if (fallEdge) begin
            bitIdx_d = bitIdx_q + 4'd1;
            if (bitIdx_q == 4'd9) begin
              dataOe_d = 1'b0;
              state_d  = ACK;
            end else begin
              dataOe_d = ~shift_q[bitIdx_q];
            end
          end
        end
        ACK: begin
          if (fallEdge) begin
            ackErr_d = dataSync_q;
            state_d  = WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (clkLine && dataSync_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FINISH;
          end
        end
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign psClk_oe  = clkOe_q;
  assign psData_oe = dataOe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_err   = ackErr_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an open-drain PS/2 device model clocks bits out and acks (or not).
module tb_ps2_host_tx;

  localparam int INHIBIT = 5000;
  localparam int RTSHOLD = 20;
  localparam int TO      = 3000;
  localparam int HALF    = 30;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       devClkLow = 1'b0;
  logic       devDataLow = 1'b0;
  logic       psClk_oe, psData_oe, busy, done, ack_err, timeout;
  logic       psClkLine, psDataLine;

  int   passCount = 0;
  int   checkCount = 0;
  int   failCount = 0;
  int   cycleCount = 0;
  int   doneCount = 0;
  int   doneCycle = 0;
  logic lastAckErr = 1'b0;
  logic lastTimeout = 1'b0;

  assign psClkLine  = !(psClk_oe || devClkLow);
  assign psDataLine = !(psData_oe || devDataLow);

  ps2_host_tx #(
    .CLK_INHIBIT_CYCLES(INHIBIT),
    .RTS_HOLD_CYCLES(RTSHOLD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .psClk_in(psClkLine),
    .psData_in(psDataLine),
    .psClk_oe(psClk_oe),
    .psData_oe(psData_oe),
    .busy(busy),
    .done(done),
    .ack_err(ack_err),
    .timeout(timeout)
  );

  always #10 Clk = ~Clk;

  always @(posedge Clk) cycleCount <= cycleCount + 1;

  // Every high sample of done is counted, so a stretched pulse shows up as an extra count.
  always @(negedge Clk) begin
    if (done) begin
      doneCount   <= doneCount + 1;
      doneCycle   <= cycleCount;
      lastAckErr  <= ack_err;
      lastTimeout <= timeout;
    end
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge Clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge Clk);
    tx_start = 1'b0;
  endtask

  // Device model; abortEdge>0 returns 10 cycles into that clock-low phase with the clock still held.
  task automatic runDevice(input int abortEdge, input bit doAck, output logic [9:0] bits,
                           output int lowCycles, output logic startBit, output bit ok);
    ok = 1'b1;
    bits = '0;
    lowCycles = 0;
    startBit = 1'b1;
    while (psClkLine === 1'b0 && lowCycles < 20000) begin
      @(negedge Clk);
      lowCycles++;
    end
    if (lowCycles >= 20000) begin
      ok = 1'b0;
      return;
    end
    repeat (10) @(negedge Clk);
    startBit = psDataLine;
    for (int e = 1; e <= 10; e++) begin
      @(negedge Clk);
      devClkLow = 1'b1;
      if (e == abortEdge) begin
        repeat (10) @(negedge Clk);
        return;
      end
      repeat (HALF) @(negedge Clk);
      bits[e-1] = psDataLine;
      devClkLow = 1'b0;
      repeat (HALF) @(negedge Clk);
    end
    devDataLow = doAck;
    repeat (5) @(negedge Clk);
    devClkLow = 1'b1;
    repeat (HALF) @(negedge Clk);
    devClkLow = 1'b0;
    repeat (5) @(negedge Clk);
    devDataLow = 1'b0;
  endtask

  task automatic waitDone(input int prev, input int limit, output bit seen);
    int n = 0;
    seen = 1'b0;
    while (n < limit) begin
      @(negedge Clk);
      #1;
      if (doneCount != prev) begin
        seen = 1'b1;
        return;
      end
      n++;
    end
  endtask

  task automatic finishTransfer(input string name, input int prev, input logic expAckErr);
    bit seen;
    waitDone(prev, 400, seen);
    checkOutput({name, "_done_seen"}, 32'(seen), 1);
    repeat (5) @(negedge Clk);
    checkOutput({name, "_done_one_cycle"}, 32'(doneCount - prev), 1);
    checkOutput({name, "_ack_err"}, 32'(lastAckErr), 32'(expAckErr));
    checkOutput({name, "_timeout"}, 32'(lastTimeout), 0);
    checkOutput({name, "_idle_outputs"}, 32'({psClk_oe, psData_oe, busy}), 0);
  endtask

  initial begin
    logic [9:0] bits;
    int         low;
    logic       startBit;
    bit         ok;
    bit         seen;
    int         prev;
    int         mark;
    int         elapsed;

    repeat (3) @(negedge Clk);
    checkOutput("reset_outputs", 32'({psClk_oe, psData_oe, busy, done, ack_err, timeout}), 0);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);

    // 0xED with ack: LSB-first 1,0,1,1,0,1,1,1, six ones so odd parity is 1.
    prev = doneCount;
    applyStimulus(8'hED);
    checkOutput("ed_busy_after_start", 32'(busy), 1);
    checkOutput("ed_clk_oe_after_start", 32'(psClk_oe), 1);
    runDevice(0, 1'b1, bits, low, startBit, ok);
    checkOutput("ed_clk_released", 32'(ok), 1);
    checkOutput("ed_inhibit_len_ok", 32'(low >= INHIBIT && low <= INHIBIT + RTSHOLD + 10), 1);
    checkOutput("ed_start_bit", 32'(startBit), 0);
    checkOutput("ed_data_bits", 32'(bits[7:0]), 32'h0000_00ED);
    checkOutput("ed_parity", 32'(bits[8]), 1);
    checkOutput("ed_stop", 32'(bits[9]), 1);
    finishTransfer("ed", prev, 1'b0);

    // 0x07: three ones, parity 0.
    prev = doneCount;
    applyStimulus(8'h07);
    runDevice(0, 1'b1, bits, low, startBit, ok);
    checkOutput("x07_data_bits", 32'(bits[7:0]), 32'h0000_0007);
    checkOutput("x07_parity", 32'(bits[8]), 0);
    finishTransfer("x07", prev, 1'b0);

    // Device leaves data high on the ack clock: 0x55 has four ones, parity 1.
    prev = doneCount;
    applyStimulus(8'h55);
    runDevice(0, 1'b0, bits, low, startBit, ok);
    checkOutput("noack_data_bits", 32'(bits[7:0]), 32'h0000_0055);
    checkOutput("noack_parity", 32'(bits[8]), 1);
    finishTransfer("noack", prev, 1'b1);

    // Second start with a different byte while busy must be ignored; 0xA5 has four ones.
    prev = doneCount;
    applyStimulus(8'hA5);
    repeat (100) @(negedge Clk);
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    @(negedge Clk);
    tx_start = 1'b0;
    checkOutput("busy_ignore_still_busy", 32'(busy), 1);
    runDevice(0, 1'b1, bits, low, startBit, ok);
    checkOutput("busy_ignore_data_bits", 32'(bits[7:0]), 32'h0000_00A5);
    checkOutput("busy_ignore_parity", 32'(bits[8]), 1);
    finishTransfer("busy_ignore", prev, 1'b0);
    checkOutput("busy_ignore_no_second", 32'(busy), 0);

    // Clocking stops after edge 4 of 0x52; bit 3 is 0, so data is driven low at the stall.
    prev = doneCount;
    applyStimulus(8'h52);
    runDevice(4, 1'b1, bits, low, startBit, ok);
    mark = cycleCount - 10;
    checkOutput("to_first_bits", 32'(bits[2:0]), 32'h0000_0002);
    checkOutput("to_data_driven_at_stall", 32'(psData_oe), 1);
    repeat (20) @(negedge Clk);
    devClkLow = 1'b0;
    waitDone(prev, TO + 500, seen);
    checkOutput("to_done_seen", 32'(seen), 1);
    elapsed = doneCycle - mark;
    checkOutput("to_latency_ok", 32'(elapsed >= TO && elapsed <= TO + 10), 1);
    checkOutput("to_timeout_flag", 32'(lastTimeout), 1);
    checkOutput("to_ack_err", 32'(lastAckErr), 0);
    checkOutput("to_lines_released", 32'({psClk_oe, psData_oe, busy}), 0);

    // Reset between clock edges during edge 5 of 0x00 (data driven low at that moment).
    prev = doneCount;
    applyStimulus(8'h00);
    runDevice(5, 1'b1, bits, low, startBit, ok);
    checkOutput("rst_pre_data_oe", 32'(psData_oe), 1);
    checkOutput("rst_pre_busy", 32'(busy), 1);
    #3;
    Reset = 1'b1;
    #1;
    checkOutput("rst_async_release", 32'({psClk_oe, psData_oe, busy}), 0);
    devClkLow = 1'b0;
    repeat (5) @(negedge Clk);
    Reset = 1'b0;
    repeat (200) @(negedge Clk);
    checkOutput("rst_no_done", 32'(doneCount - prev), 0);

    // 0xFF after the reset: eight ones, parity 1.
    prev = doneCount;
    applyStimulus(8'hFF);
    runDevice(0, 1'b1, bits, low, startBit, ok);
    checkOutput("ff_start_bit", 32'(startBit), 0);
    checkOutput("ff_data_bits", 32'(bits[7:0]), 32'h0000_00FF);
    checkOutput("ff_parity", 32'(bits[8]), 1);
    checkOutput("ff_stop", 32'(bits[9]), 1);
    finishTransfer("ff", prev, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
